// File: rtl/mem_dump_sequencer.sv
// Memory dump sequencer: walks NUM_LINES words from BASE_ADDR by STRIDE and streams {addr,data} beats.
// Latency: START_DELAY cycles after trigger to first request; min 3 cycles per beat (REQ, WAIT, OUT).
// Backpressure: request held until mem_req_ready_i, beat held until dump_ready_i; one read outstanding.
module mem_dump_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0100_0000,
    parameter int                STRIDE      = 4,
    parameter int                NUM_LINES   = 256,
    parameter int                START_DELAY = 3,
    parameter bit                AUTO_START  = 1'b1,
    localparam int               CNT_W       = ($clog2(NUM_LINES + 1) < 1) ? 1 : $clog2(NUM_LINES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              rsp_err_o
);

    // Delay counter runs 0 .. START_DELAY-1 while in DELAY.
    localparam int               DLY_W    = (START_DELAY < 2) ? 1 : $clog2(START_DELAY);
    localparam logic [DLY_W-1:0] LAST_DLY = DLY_W'((START_DELAY == 0) ? 0 : START_DELAY - 1);
    // Count value held while the final beat of a dump is on the output.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((NUM_LINES == 0) ? 0 : NUM_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic              armed_q;
    logic [DLY_W-1:0]  dly_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  count_q;
    logic              req_vld_q;
    logic              dump_vld_q;
    logic [ADDR_W-1:0] dump_addr_q;
    logic [DATA_W-1:0] dump_data_q;
    logic              busy_q;
    logic              done_q;
    logic              rsp_err_q;

    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  count_d;

    // Next address and beat count on a beat accept; address wraps silently.
    always_comb begin
        addr_d  = addr_q + ADDR_W'(STRIDE);
        count_d = count_q + 1'b1;
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            armed_q     <= AUTO_START;
            dly_q       <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            req_vld_q   <= 1'b0;
            dump_vld_q  <= 1'b0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            // A response can only be matched to a request while waiting for it.
            if (mem_rsp_valid_i && (state_q != S_WAIT)) begin
                rsp_err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i || armed_q) begin
                        armed_q <= 1'b0;
                        addr_q  <= BASE_ADDR;
                        count_q <= '0;
                        dly_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        if (START_DELAY != 0) begin
                            state_q <= S_DELAY;
                        end else if (NUM_LINES == 0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_REQ;
                            req_vld_q <= 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    if (dly_q == LAST_DLY) begin
                        if (NUM_LINES == 0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_REQ;
                            req_vld_q <= 1'b1;
                        end
                    end else begin
                        dly_q <= dly_q + 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready_i) begin
                        req_vld_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        dump_data_q <= mem_rsp_data_i;
                        dump_addr_q <= addr_q;
                        dump_vld_q  <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (dump_ready_i) begin
                        dump_vld_q <= 1'b0;
                        count_q    <= count_d;
                        addr_q     <= addr_d;
                        if (count_q == LAST_CNT) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_REQ;
                            req_vld_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid_o = req_vld_q;
    assign mem_addr_o      = addr_q;
    assign dump_valid_o    = dump_vld_q;
    assign dump_addr_o     = dump_addr_q;
    assign dump_data_o     = dump_data_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign count_o         = count_q;
    assign rsp_err_o       = rsp_err_q;

endmodule
